// File: rtl/rv32_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rv32_mem_pkg
// Description : Shared definitions for the data-memory access path:
//               RV32I load/store funct3 codes, the access sequencer state
//               encoding and a helper returning the access size in bytes.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Size of the access in bytes; the low two funct3 bits carry the width.
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    access_bytes = 3'd1;
      2'd1:    access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_access_check.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_check
// Description : Combinational legality check for one load/store access.
//               Flags unsupported funct3 codes, misaligned halfword/word
//               accesses and any access touching bytes beyond the
//               2**ADDR_W-byte memory.
// Ports       : we     - 1 = store, 0 = load
//               funct3 - RV32I funct3 of the access
//               addr   - byte address
//               err    - 1 = access must be rejected
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_check
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  output logic        err
);

  localparam logic [32:0] LAST_BYTE = 33'((64'd1 << ADDR_W) - 64'd1);

  logic        f3_ok;
  logic        align_ok;
  logic        range_ok;
  logic [2:0]  nbytes;
  logic [32:0] last_byte;

  always_comb begin
    f3_ok = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: f3_ok = 1'b1;
      F3_BU, F3_HU:     f3_ok = !we;   // unsigned variants exist only for loads
      default:          f3_ok = 1'b0;
    endcase

    nbytes = access_bytes(funct3);

    align_ok = 1'b1;
    case (nbytes)
      3'd2:    align_ok = (addr[0] == 1'b0);
      3'd4:    align_ok = (addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase

    // Computed in 33 bits so an access near 0xFFFF_FFFF cannot wrap.
    last_byte = {1'b0, addr} + {30'd0, nbytes} - 33'd1;
    range_ok  = ((addr >> ADDR_W) == 32'd0) && (last_byte <= LAST_BYTE);

    err = !(f3_ok && align_ok && range_ok);
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-requester arbiter and access sequencer in front of the
//               shared byte-addressed data memory. One access at a time:
//               IDLE (arbitrate/accept) -> ISSUE (one memory cycle) -> RESP
//               (one-cycle response). Illegal accesses skip ISSUE.
// Ports       : clk, rst_n          - clock, synchronous active-low reset
//               req_valid/req_ready - per-requester handshake (bit i = req i)
//               req_we, req_addr*, req_wdata*, req_funct3_* - request fields
//               rsp_valid, rsp_rdata, rsp_err - one-cycle response
//               mem_*               - memory port (address/data/strobes)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int RR_EN  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_we,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  input  logic [2:0]  req_funct3_0,
  input  logic [2:0]  req_funct3_1,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic [2:0]  mem_funct3,
  output logic        mem_MemWrite,
  output logic        mem_MemRead,
  input  logic [31:0] mem_readData
);

  state_t      state;
  state_t      state_nxt;
  logic        rr_ptr;     // favoured requester; stays 0 with RR_EN=0
  logic        owner;      // requester that owns the access in flight
  logic [1:0]  grant;
  logic        accept;
  logic        sel;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_f3;
  logic        sel_err;

  assign req_ready = grant;
  assign accept    = |grant;
  assign sel       = grant[1];
  assign sel_we    = sel ? req_we[1]    : req_we[0];
  assign sel_addr  = sel ? req_addr1    : req_addr0;
  assign sel_wdata = sel ? req_wdata1   : req_wdata0;
  assign sel_f3    = sel ? req_funct3_1 : req_funct3_0;

  dmem_access_check #(
    .ADDR_W (ADDR_W)
  ) u_check (
    .we     (sel_we),
    .funct3 (sel_f3),
    .addr   (sel_addr),
    .err    (sel_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Grant is gated by rst_n so nothing can be accepted while held in reset.
  always_comb begin
    grant     = 2'b00;
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (rst_n) begin
          if (req_valid[rr_ptr])       grant[rr_ptr]  = 1'b1;
          else if (req_valid[~rr_ptr]) grant[~rr_ptr] = 1'b1;
        end
        if (|grant) state_nxt = sel_err ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The mem_address/mem_writeData/mem_funct3 registers double as the request
  // latch; they only load on a legal accept, so they hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr        <= 1'b0;
      owner         <= 1'b0;
      mem_address   <= 32'd0;
      mem_writeData <= 32'd0;
      mem_funct3    <= 3'd0;
      mem_MemWrite  <= 1'b0;
      mem_MemRead   <= 1'b0;
      rsp_valid     <= 2'b00;
      rsp_rdata     <= 32'd0;
      rsp_err       <= 1'b0;
    end else begin
      mem_MemWrite <= 1'b0;
      mem_MemRead  <= 1'b0;
      rsp_valid    <= 2'b00;
      rsp_rdata    <= 32'd0;
      rsp_err      <= 1'b0;

      if (accept) begin
        owner <= sel;
        if (sel_err) begin
          rsp_valid <= sel ? 2'b10 : 2'b01;
          rsp_err   <= 1'b1;
        end else begin
          mem_address   <= sel_addr;
          mem_writeData <= sel_wdata;
          mem_funct3    <= sel_f3;
          mem_MemWrite  <= sel_we;
          mem_MemRead   <= !sel_we;
        end
      end

      if (state == ST_ISSUE) begin
        rsp_valid <= owner ? 2'b10 : 2'b01;
        if (mem_MemRead) rsp_rdata <= mem_readData;
      end

      if ((RR_EN != 0) && (state == ST_RESP)) rr_ptr <= ~owner;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench. Instance 0 runs round-robin, instance 1
//               fixed priority. A transaction-level model predicts grants,
//               memory strobes and responses cycle by cycle; a byte-array
//               memory sits behind each DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int NCYC = 1500;
  localparam int NDIR = 9;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req_valid [2];
  logic [1:0]  req_ready [2];
  logic [1:0]  req_we    [2];
  logic [31:0] req_addr  [2][2];
  logic [31:0] req_wdata [2][2];
  logic [2:0]  req_f3    [2][2];
  logic [1:0]  rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wd    [2];
  logic [2:0]  mem_f3    [2];
  logic        mem_we    [2];
  logic        mem_re    [2];
  logic [31:0] mem_rdata [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_arbiter #(
      .ADDR_W (12),
      .RR_EN  ((g == 0) ? 1 : 0)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid[g]),
      .req_ready     (req_ready[g]),
      .req_we        (req_we[g]),
      .req_addr0     (req_addr[g][0]),
      .req_addr1     (req_addr[g][1]),
      .req_wdata0    (req_wdata[g][0]),
      .req_wdata1    (req_wdata[g][1]),
      .req_funct3_0  (req_f3[g][0]),
      .req_funct3_1  (req_f3[g][1]),
      .rsp_valid     (rsp_valid[g]),
      .rsp_rdata     (rsp_rdata[g]),
      .rsp_err       (rsp_err[g]),
      .mem_address   (mem_addr[g]),
      .mem_writeData (mem_wd[g]),
      .mem_funct3    (mem_f3[g]),
      .mem_MemWrite  (mem_we[g]),
      .mem_MemRead   (mem_re[g]),
      .mem_readData  (mem_rdata[g])
    );
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Environment memory (behind the DUT) and the model's own view of memory.
  logic [7:0] env_mem [2][4096];
  logic [7:0] ref_mem [2][4096];

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit is_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int nb;
    nb = size_of(f3);
    if (nb == 0) return 1'b0;
    if (we && f3 > 3'd2) return 1'b0;
    if ((addr % nb) != 0) return 1'b0;
    if (longint'(addr) + nb - 1 > 4095) return 1'b0;
    return 1'b1;
  endfunction

  // Memory-side extension as the data memory performs it.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] raw);
    case (f3)
      3'd0:    return {{24{raw[7]}}, raw[7:0]};
      3'd4:    return {24'd0, raw[7:0]};
      3'd1:    return {{16{raw[15]}}, raw[15:0]};
      3'd5:    return {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int   nb;
    r.we    = 1'($urandom_range(0, 1));
    r.wdata = $urandom;
    case ($urandom_range(0, 9))
      0:       r.f3 = 3'($urandom_range(3, 3));
      1:       r.f3 = 3'($urandom_range(6, 7));
      2, 3:    r.f3 = 3'd2;
      4, 5:    r.f3 = 3'd0;
      6:       r.f3 = 3'd1;
      7:       r.f3 = 3'd4;
      default: r.f3 = 3'd5;
    endcase
    case ($urandom_range(0, 7))
      6:       r.addr = 32'hFF8 + 32'($urandom_range(0, 7));
      7:       r.addr = ($urandom_range(0, 1) == 1) ? 32'h1000 + 32'($urandom_range(0, 3)) : $urandom;
      default: r.addr = 32'($urandom_range(0, 63));
    endcase
    nb = size_of(r.f3);
    if (nb > 1 && $urandom_range(0, 9) < 6) r.addr = r.addr & ~32'(nb - 1);
    return r;
  endfunction

  req_t dir_list [NDIR];
  int   dir_idx  [2];
  req_t pend     [2][2];
  logic pend_v   [2][2];

  // Model state, per instance.
  int          idle_from [2];
  int          issue_c   [2];
  int          resp_c    [2];
  int          favored   [2];
  logic        issue_we  [2];
  logic [1:0]  own_vec   [2];
  logic        exp_err_r [2];
  logic [31:0] exp_dat_r [2];
  logic [31:0] exp_maddr [2];
  logic [31:0] exp_mwd   [2];
  logic [2:0]  exp_mf3   [2];
  int          acc_cnt   [2][2];

  initial begin
    dir_list[0] = '{we: 1'b1, f3: 3'd2, addr: 32'h10,  wdata: 32'hDEADBEEF};
    dir_list[1] = '{we: 1'b0, f3: 3'd2, addr: 32'h10,  wdata: 32'h0};
    dir_list[2] = '{we: 1'b0, f3: 3'd1, addr: 32'h11,  wdata: 32'h0};
    dir_list[3] = '{we: 1'b0, f3: 3'd2, addr: 32'h22,  wdata: 32'h0};
    dir_list[4] = '{we: 1'b0, f3: 3'd3, addr: 32'h20,  wdata: 32'h0};
    dir_list[5] = '{we: 1'b1, f3: 3'd2, addr: 32'hFFE, wdata: 32'h12345678};
    dir_list[6] = '{we: 1'b0, f3: 3'd0, addr: 32'h1000, wdata: 32'h0};
    dir_list[7] = '{we: 1'b1, f3: 3'd0, addr: 32'hFFF, wdata: 32'h000000A5};
    dir_list[8] = '{we: 1'b0, f3: 3'd4, addr: 32'hFFF, wdata: 32'h0};

    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4096; k++) begin
        env_mem[d][k] = 8'($urandom);
        ref_mem[d][k] = env_mem[d][k];
      end
      dir_idx[d]   = 0;
      idle_from[d] = 0;
      issue_c[d]   = -1;
      resp_c[d]    = -1;
      favored[d]   = 0;
      issue_we[d]  = 1'b0;
      own_vec[d]   = 2'b00;
      exp_err_r[d] = 1'b0;
      exp_dat_r[d] = 32'd0;
      exp_maddr[d] = 32'd0;
      exp_mwd[d]   = 32'd0;
      exp_mf3[d]   = 3'd0;
      mem_rdata[d] = 32'd0;
      req_valid[d] = 2'b00;
      req_we[d]    = 2'b00;
      for (int i = 0; i < 2; i++) begin
        pend_v[d][i]    = 1'b0;
        pend[d][i]      = '0;
        req_addr[d][i]  = 32'd0;
        req_wdata[d][i] = 32'd0;
        req_f3[d][i]    = 3'd0;
        acc_cnt[d][i]   = 0;
      end
    end

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      rst_n = !(c < 3 || (c > 80 && $urandom_range(0, 49) == 0));

      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 2; i++) begin
          if (!pend_v[d][i]) begin
            if (i == 0 && dir_idx[d] < NDIR) begin
              pend[d][i]   = dir_list[dir_idx[d]];
              pend_v[d][i] = 1'b1;
              dir_idx[d]++;
            end else if (c >= 40 && $urandom_range(0, 9) < 6) begin
              pend[d][i]   = rand_req();
              pend_v[d][i] = 1'b1;
            end
          end
          req_valid[d][i] = pend_v[d][i];
          req_we[d][i]    = pend[d][i].we;
          req_addr[d][i]  = pend[d][i].addr;
          req_wdata[d][i] = pend[d][i].wdata;
          req_f3[d][i]    = pend[d][i].f3;
        end
        mem_rdata[d] = load_ext(mem_f3[d], {env_mem[d][12'(mem_addr[d] + 32'd3)],
                                            env_mem[d][12'(mem_addr[d] + 32'd2)],
                                            env_mem[d][12'(mem_addr[d] + 32'd1)],
                                            env_mem[d][12'(mem_addr[d])]});
      end

      #1;

      for (int d = 0; d < 2; d++) begin
        logic [1:0] exp_ready;
        int         win;
        bit         in_resp;
        bit         in_issue;

        exp_ready = 2'b00;
        win       = -1;
        if (rst_n && c >= idle_from[d]) begin
          if (pend_v[d][favored[d]])          win = favored[d];
          else if (pend_v[d][1 - favored[d]]) win = 1 - favored[d];
          if (win >= 0) exp_ready[win] = 1'b1;
        end
        in_resp  = (c == resp_c[d]);
        in_issue = (c == issue_c[d]);

        check_eq($sformatf("ready[%0d]@%0d", d, c),  32'(req_ready[d]), 32'(exp_ready));
        check_eq($sformatf("rsp_valid[%0d]@%0d", d, c), 32'(rsp_valid[d]), in_resp ? 32'(own_vec[d]) : 32'd0);
        check_eq($sformatf("rsp_err[%0d]@%0d", d, c), 32'(rsp_err[d]), (in_resp && exp_err_r[d]) ? 32'd1 : 32'd0);
        check_eq($sformatf("rsp_rdata[%0d]@%0d", d, c), rsp_rdata[d], in_resp ? exp_dat_r[d] : 32'd0);
        check_eq($sformatf("MemWrite[%0d]@%0d", d, c), 32'(mem_we[d]), (in_issue && issue_we[d]) ? 32'd1 : 32'd0);
        check_eq($sformatf("MemRead[%0d]@%0d", d, c), 32'(mem_re[d]), (in_issue && !issue_we[d]) ? 32'd1 : 32'd0);
        check_eq($sformatf("mem_address[%0d]@%0d", d, c), mem_addr[d], exp_maddr[d]);
        check_eq($sformatf("mem_writeData[%0d]@%0d", d, c), mem_wd[d], exp_mwd[d]);
        check_eq($sformatf("mem_funct3[%0d]@%0d", d, c), 32'(mem_f3[d]), 32'(exp_mf3[d]));

        // Memory commits whatever the DUT strobes at the coming edge.
        if (mem_we[d] === 1'b1) begin
          for (int k = 0; k < size_of(mem_f3[d]); k++)
            env_mem[d][12'(mem_addr[d] + 32'(k))] = mem_wd[d][8*k +: 8];
        end

        if (!rst_n) begin
          issue_c[d]   = -1;
          resp_c[d]    = -1;
          idle_from[d] = c + 1;
          favored[d]   = 0;
          exp_maddr[d] = 32'd0;
          exp_mwd[d]   = 32'd0;
          exp_mf3[d]   = 3'd0;
        end else if (win >= 0) begin
          req_t r;
          r            = pend[d][win];
          pend_v[d][win] = 1'b0;
          acc_cnt[d][win]++;
          own_vec[d]   = (win == 1) ? 2'b10 : 2'b01;
          if (d == 0) favored[d] = 1 - win;
          if (is_legal(r.we, r.f3, r.addr)) begin
            int nb;
            longint v;
            nb           = size_of(r.f3);
            issue_c[d]   = c + 1;
            resp_c[d]    = c + 2;
            idle_from[d] = c + 3;
            issue_we[d]  = r.we;
            exp_err_r[d] = 1'b0;
            exp_maddr[d] = r.addr;
            exp_mwd[d]   = r.wdata;
            exp_mf3[d]   = r.f3;
            if (r.we) begin
              for (int k = 0; k < nb; k++) ref_mem[d][r.addr + k] = r.wdata[8*k +: 8];
              exp_dat_r[d] = 32'd0;
            end else begin
              v = 0;
              for (int k = 0; k < nb; k++) v += longint'(ref_mem[d][r.addr + k]) << (8 * k);
              if ((r.f3 == 3'd0 || r.f3 == 3'd1) && v >= (longint'(1) << (8 * nb - 1)))
                v -= longint'(1) << (8 * nb);
              exp_dat_r[d] = v[31:0];
            end
          end else begin
            issue_c[d]   = -1;
            resp_c[d]    = c + 1;
            idle_from[d] = c + 2;
            exp_err_r[d] = 1'b1;
            exp_dat_r[d] = 32'd0;
          end
        end
      end
    end

    check_eq("rr_req1_served", 32'(acc_cnt[0][1] > 20), 32'd1);
    check_eq("rr_req0_served", 32'(acc_cnt[0][0] > 20), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
